// File: rtl/btn_step_gen.sv
// Push-button front end: synchronises a raw bouncing button, debounces it and
// emits clean one-cycle step pulses, with optional auto-repeat while held.
module btn_step_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic CLK,
  input  logic rst,
  input  logic iBtn,
  input  logic iAutoEn,
  output logic oStep,
  output logic oPressed,
  output logic oRepeating
);

  localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int CNT_MAX = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    HELD,
    REPEAT,
    DB_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          syncMeta_q, btnSync_q;
  logic          step_q, step_d;
  logic          pressed_q, pressed_d;
  logic          repeating_q;

  // The button is asynchronous to CLK, so only the second flop is ever observed.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      syncMeta_q <= 1'b0;
      btnSync_q  <= 1'b0;
    end else begin
      syncMeta_q <= iBtn;
      btnSync_q  <= syncMeta_q;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_ZERO;
      step_q      <= 1'b0;
      pressed_q   <= 1'b0;
      repeating_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      pressed_q   <= pressed_d;
      repeating_q <= (state_d == REPEAT);
    end
  end

  // A low synchronised button always wins over auto-repeat and terminal counts.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_d    = 1'b0;
    pressed_d = pressed_q;

    case (state_q)
      IDLE: begin
        cnt_d = CNT_ZERO;
        if (btnSync_q) begin
          state_d = DB_PRESS;
        end
      end

      DB_PRESS: begin
        if (!btnSync_q) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == DB_LAST) begin
          state_d   = HELD;
          cnt_d     = CNT_ZERO;
          step_d    = 1'b1;
          pressed_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      HELD: begin
        if (!btnSync_q) begin
          state_d = DB_RELEASE;
          cnt_d   = CNT_ZERO;
        end else if (iAutoEn) begin
          if (cnt_q == RD_LAST) begin
            state_d = REPEAT;
            cnt_d   = CNT_ZERO;
            step_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = CNT_ZERO;
        end
      end

      REPEAT: begin
        if (!btnSync_q) begin
          state_d = DB_RELEASE;
          cnt_d   = CNT_ZERO;
        end else if (!iAutoEn) begin
          state_d = HELD;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == RP_LAST) begin
          cnt_d  = CNT_ZERO;
          step_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DB_RELEASE: begin
        if (btnSync_q) begin
          state_d = HELD;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == DB_LAST) begin
          state_d   = IDLE;
          cnt_d     = CNT_ZERO;
          pressed_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  assign oStep      = step_q;
  assign oPressed   = pressed_q;
  assign oRepeating = repeating_q;

  // Back-to-back steps would double-advance the downstream counter.
  assert property (@(posedge CLK) disable iff (rst) step_q |=> !step_q);

endmodule

// File: tb/tb_btn_step_gen.sv
// Bench for btn_step_gen: directed scenarios plus random button traffic, all
// checked against a run-length based reference model of the debouncer.
module tb_btn_step_gen;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic CLK = 1'b0;
  logic rst;
  logic iBtn;
  logic iAutoEn;
  logic oStep;
  logic oPressed;
  logic oRepeating;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: two-sample delay line, accepted level, run of samples
  // disagreeing with it, and count of qualifying held-with-auto-repeat edges.
  bit mS1, mS2, mLvl, mStep, mRep;
  int mRun, mHold;

  btn_step_gen #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .CLK       (CLK),
    .rst       (rst),
    .iBtn      (iBtn),
    .iAutoEn   (iAutoEn),
    .oStep     (oStep),
    .oPressed  (oPressed),
    .oRepeating(oRepeating)
  );

  always #5 CLK = ~CLK;

  task automatic modelReset();
    mS1 = 0; mS2 = 0; mLvl = 0; mStep = 0; mRep = 0;
    mRun = 0; mHold = 0;
  endtask

  // Advance one rising edge, update the model, and return on the falling edge.
  task automatic tick();
    bit s;
    @(posedge CLK);
    s   = mS2;
    mS2 = mS1;
    mS1 = iBtn;
    mStep = 0;
    if (s != mLvl) begin
      mRun++;
      mHold = 0;
      if (mRun == D + 1) begin
        mLvl  = s;
        mRun  = 0;
        mStep = s;
      end
    end else begin
      if (mLvl && mRun == 0 && iAutoEn) begin
        mHold++;
        if (mHold >= RD && ((mHold - RD) % RP) == 0) mStep = 1;
      end else begin
        mHold = 0;
      end
      mRun = 0;
    end
    mRep = mLvl && (mRun == 0) && (mHold >= RD);
    @(negedge CLK);
  endtask

  task automatic doReset();
    rst = 1'b1; iBtn = 1'b0; iAutoEn = 1'b0;
    modelReset();
    repeat (2) @(negedge CLK);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int stepIdx;
    rst = 1'b1; iBtn = 1'b0; iAutoEn = 1'b0;
    modelReset();
    @(negedge CLK);
    checkCount++;
    if ({oStep, oPressed, oRepeating} !== 3'b000)
      $display("[TB] FAIL reset_idle: outputs=%b%b%b expected 000", oStep, oPressed, oRepeating);
    else passCount++;

    rst = 1'b0; iBtn = 1'b1;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    checkCount++;
    if ({oStep, oPressed, oRepeating} !== 3'b000)
      $display("[TB] FAIL reset_mid_press: outputs=%b%b%b expected 000", oStep, oPressed, oRepeating);
    else passCount++;
    modelReset();
    @(negedge CLK);
    rst = 1'b0;

    stepIdx = -1;
    iAutoEn = 1'b1;
    for (int k = 0; k < 17; k++) begin
      tick();
      if (oStep === 1'b1 && stepIdx < 0) stepIdx = k;
      checkCount++;
      if ({oStep, oPressed, oRepeating} !== {mStep, mLvl, mRep})
        $display("[TB] FAIL reset_rebounce k=%0d: got %b%b%b expected %b%b%b",
                 k, oStep, oPressed, oRepeating, mStep, mLvl, mRep);
      else passCount++;
    end
    checkCount++;
    if (stepIdx != D + 2)
      $display("[TB] FAIL reset_first_step: step at edge %0d expected %0d", stepIdx, D + 2);
    else passCount++;

    #2 rst = 1'b1;
    #1;
    checkCount++;
    if ({oStep, oPressed, oRepeating} !== 3'b000)
      $display("[TB] FAIL reset_mid_repeat: outputs=%b%b%b expected 000", oStep, oPressed, oRepeating);
    else passCount++;
    modelReset();
    iBtn = 1'b0; iAutoEn = 1'b0;
    @(negedge CLK);
    rst = 1'b0;
  endtask

  task automatic test_clean_press();
    int pulses, firstIdx, fallIdx;
    doReset();
    iBtn = 1'b1;
    pulses = 0; firstIdx = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (oStep === 1'b1) begin
        pulses++;
        if (firstIdx < 0) firstIdx = k;
      end
      checkCount++;
      if ({oStep, oPressed, oRepeating} !== {mStep, mLvl, mRep})
        $display("[TB] FAIL clean_press k=%0d: got %b%b%b expected %b%b%b",
                 k, oStep, oPressed, oRepeating, mStep, mLvl, mRep);
      else passCount++;
    end
    checkCount++;
    if (pulses != 1 || firstIdx != 6)
      $display("[TB] FAIL clean_press_pulse: %0d pulses first at %0d, expected 1 at 6", pulses, firstIdx);
    else passCount++;

    iBtn = 1'b0;
    fallIdx = -1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (oPressed === 1'b0 && fallIdx < 0) fallIdx = k;
    end
    checkCount++;
    if (fallIdx != 6)
      $display("[TB] FAIL clean_release: oPressed fell at %0d expected 6", fallIdx);
    else passCount++;
  endtask

  task automatic test_press_bounce();
    int pulses, stepIdx;
    doReset();
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      iBtn = ((i / 2) % 2 == 0);
      tick();
      if (oStep === 1'b1) pulses++;
    end
    checkCount++;
    if (pulses != 0 || oPressed !== 1'b0)
      $display("[TB] FAIL press_bounce_quiet: %0d steps oPressed=%b expected 0 steps, 0", pulses, oPressed);
    else passCount++;

    iBtn = 1'b1;
    stepIdx = -1;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (oStep === 1'b1) begin
        pulses++;
        stepIdx = k;
      end
      checkCount++;
      if ({oStep, oPressed, oRepeating} !== {mStep, mLvl, mRep})
        $display("[TB] FAIL press_bounce k=%0d: got %b%b%b expected %b%b%b",
                 k, oStep, oPressed, oRepeating, mStep, mLvl, mRep);
      else passCount++;
    end
    checkCount++;
    if (pulses != 1 || stepIdx != 6)
      $display("[TB] FAIL press_bounce_step: %0d steps last at %0d expected 1 at 6", pulses, stepIdx);
    else passCount++;
  endtask

  task automatic test_release_bounce();
    int fallIdx;
    doReset();
    iBtn = 1'b1;
    repeat (10) tick();
    for (int k = 0; k < 12; k++) begin
      iBtn = (k >= 2);
      tick();
      checkCount++;
      if (oStep !== 1'b0 || oPressed !== 1'b1)
        $display("[TB] FAIL release_bounce k=%0d: oStep=%b oPressed=%b expected 0,1", k, oStep, oPressed);
      else passCount++;
    end
    iBtn = 1'b0;
    fallIdx = -1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (oPressed === 1'b0 && fallIdx < 0) fallIdx = k;
      checkCount++;
      if ({oStep, oPressed, oRepeating} !== {mStep, mLvl, mRep})
        $display("[TB] FAIL release_stable k=%0d: got %b%b%b expected %b%b%b",
                 k, oStep, oPressed, oRepeating, mStep, mLvl, mRep);
      else passCount++;
    end
    checkCount++;
    if (fallIdx != 6)
      $display("[TB] FAIL release_fall: oPressed fell at %0d expected 6", fallIdx);
    else passCount++;
  endtask

  task automatic test_auto_repeat();
    bit expStep, expRep;
    doReset();
    iAutoEn = 1'b1;
    iBtn = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      expStep = (k == 6) || (k >= 14 && ((k - 14) % 3) == 0);
      expRep  = (k >= 14);
      checkCount++;
      if (oStep !== expStep || oRepeating !== expRep)
        $display("[TB] FAIL auto_repeat k=%0d: oStep=%b oRepeating=%b expected %b,%b",
                 k, oStep, oRepeating, expStep, expRep);
      else passCount++;
      checkCount++;
      if ({oStep, oPressed, oRepeating} !== {mStep, mLvl, mRep})
        $display("[TB] FAIL auto_repeat_model k=%0d: got %b%b%b expected %b%b%b",
                 k, oStep, oPressed, oRepeating, mStep, mLvl, mRep);
      else passCount++;
    end
    iAutoEn = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checkCount++;
      if (oStep !== 1'b0 || oRepeating !== 1'b0 || oPressed !== 1'b1)
        $display("[TB] FAIL auto_stop k=%0d: oStep=%b oRepeating=%b oPressed=%b expected 0,0,1",
                 k, oStep, oRepeating, oPressed);
      else passCount++;
    end
  endtask

  task automatic test_release_in_repeat();
    bit expStep, expRep, expPressed;
    doReset();
    iAutoEn = 1'b1;
    for (int k = 0; k < 30; k++) begin
      iBtn = (k < 18);
      tick();
      expStep    = (k == 6) || (k == 14) || (k == 17);
      expRep     = (k >= 14) && (k < 20);
      expPressed = (k >= 6) && (k < 24);
      checkCount++;
      if ({oStep, oPressed, oRepeating} !== {expStep, expPressed, expRep})
        $display("[TB] FAIL release_in_repeat k=%0d: got %b%b%b expected %b%b%b",
                 k, oStep, oPressed, oRepeating, expStep, expPressed, expRep);
      else passCount++;
    end
  endtask

  task automatic test_random();
    int holdLeft;
    bit prevStep;
    doReset();
    holdLeft = 0;
    prevStep = 0;
    for (int n = 0; n < 3000; n++) begin
      if (holdLeft == 0) begin
        iBtn = $urandom_range(0, 1);
        holdLeft = (($urandom_range(0, 3) == 0) ? $urandom_range(10, 60) : $urandom_range(1, 6));
      end
      holdLeft--;
      if ($urandom_range(0, 49) == 0) iAutoEn = ~iAutoEn;
      tick();
      checkCount++;
      if ({oStep, oPressed, oRepeating} !== {mStep, mLvl, mRep})
        $display("[TB] FAIL random n=%0d: got %b%b%b expected %b%b%b",
                 n, oStep, oPressed, oRepeating, mStep, mLvl, mRep);
      else passCount++;
      checkCount++;
      if (prevStep && oStep === 1'b1)
        $display("[TB] FAIL random_consecutive n=%0d: oStep=1 after a step cycle, expected 0", n);
      else passCount++;
      prevStep = (oStep === 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_auto_repeat();
    test_release_in_repeat();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation ran past 2000000 time units");
    $fatal(1, "[TB] timeout");
  end

endmodule
